// File: rtl/instr_fetch_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : instr_fetch_unit
// Description : Sequential PC generator with a pipelined instruction-memory read
//               port, a small in-order instruction buffer and redirect/flush.
//               Optional macro IFU_COMPRESSED_CHECK_EN adds instr_illegal.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_data,
    output logic [XLEN-1:0] instr_pc,
`ifdef IFU_COMPRESSED_CHECK_EN
    output logic [6:0]      instr_opcode,
    output logic            instr_illegal
`else
    output logic [6:0]      instr_opcode
`endif
);

    localparam int                 c_PTR_W = $clog2(BUF_DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W:0]   c_DEPTH = (c_CNT_W + 1)'(BUF_DEPTH);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(BUF_DEPTH);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);
    localparam logic [XLEN-1:0]    c_WORD  = XLEN'(4);

    logic [XLEN-1:0]    r_fetch_pc;
    logic [XLEN-1:0]    r_resp_pc;
    logic [c_CNT_W-1:0] r_outstanding;
    logic [c_CNT_W-1:0] r_drop_cnt;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [XLEN-1:0]    r_buf_data [BUF_DEPTH];
    logic [XLEN-1:0]    r_buf_pc   [BUF_DEPTH];

    logic               w_credit_ok;
    logic               w_req_fire;
    logic               w_resp_drop;
    logic               w_push;
    logic               w_pop;
    logic [XLEN-1:0]    w_redirect_pc;
    logic [c_CNT_W-1:0] w_out_nxt;
    logic [c_CNT_W-1:0] w_drop_nxt;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic               w_unused;

    // Credit: reads in flight plus buffered words never exceed the buffer size.
    assign w_credit_ok    = ({1'b0, r_outstanding} + {1'b0, r_count}) < c_DEPTH;
    assign imem_req_valid = !rst && !redirect_valid && w_credit_ok;
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_resp_drop    = imem_resp_valid && (r_drop_cnt != '0);
    assign w_push         = imem_resp_valid && !w_resp_drop && !redirect_valid;
    assign w_pop          = instr_valid && instr_ready && !redirect_valid;
    assign w_redirect_pc  = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_unused       = ^redirect_pc[1:0];

    assign instr_valid  = (r_count != '0);
    assign instr_data   = r_buf_data[r_rd_ptr];
    assign instr_pc     = r_buf_pc[r_rd_ptr];
    assign instr_opcode = instr_data[6:0];
`ifdef IFU_COMPRESSED_CHECK_EN
    assign instr_illegal = instr_valid && (instr_data[1:0] != 2'b11);
`endif

    always_comb begin
        w_out_nxt   = r_outstanding;
        w_drop_nxt  = r_drop_cnt;
        w_count_nxt = r_count;

        if (w_req_fire) begin
            w_out_nxt = w_out_nxt + c_ONE;
        end
        if (imem_resp_valid) begin
            w_out_nxt = w_out_nxt - c_ONE;
        end

        // outstanding already covers reads marked for drop, so after a redirect
        // everything still in flight (minus this cycle's response) is discarded.
        if (redirect_valid) begin
            w_drop_nxt = imem_resp_valid ? (r_outstanding - c_ONE) : r_outstanding;
        end else if (w_resp_drop) begin
            w_drop_nxt = r_drop_cnt - c_ONE;
        end

        if (redirect_valid) begin
            w_count_nxt = '0;
        end else begin
            if (w_push) begin
                w_count_nxt = w_count_nxt + c_ONE;
            end
            if (w_pop) begin
                w_count_nxt = w_count_nxt - c_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            r_outstanding <= w_out_nxt;
            r_drop_cnt    <= w_drop_nxt;
            r_count       <= w_count_nxt;

            if (redirect_valid) begin
                r_fetch_pc <= w_redirect_pc;
                r_resp_pc  <= w_redirect_pc;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + c_WORD;
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + c_WORD;
                    r_wr_ptr  <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end

            assert (!(imem_resp_valid && (r_outstanding == '0)));
            assert (!(w_push && !w_pop && (r_count == c_FULL)));
        end
    end

    // Storage carries no reset; validity lives entirely in r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_data[r_wr_ptr] <= imem_resp_data;
            r_buf_pc[r_wr_ptr]   <= r_resp_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_instr_fetch_unit
// Description : Directed scoreboard bench for instr_fetch_unit with a pipelined
//               memory model. Honours IFU_COMPRESSED_CHECK_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data  = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic [6:0]  instr_opcode;
`ifdef IFU_COMPRESSED_CHECK_EN
    logic        instr_illegal;
`endif

    typedef struct {logic [31:0] pc; logic [31:0] data;} exp_t;
    typedef struct {logic [31:0] addr; int unsigned cyc;} mreq_t;

    exp_t        sb[$];
    mreq_t       memq[$];
    logic [31:0] dlog[$];
    exp_t        e;
    logic [31:0] exp_fetch_pc = '0;
    bit          resp_en = 1'b1;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;
    int          n_acc = 0;

    instr_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_data      (instr_data),
        .instr_pc        (instr_pc),
`ifdef IFU_COMPRESSED_CHECK_EN
        .instr_opcode    (instr_opcode),
        .instr_illegal   (instr_illegal)
`else
        .instr_opcode    (instr_opcode)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'hFFFF_FFFC) return 32'h0000_4501;
        if (a == 32'h0000_0000) return 32'h0000_0013;
        return {a[23:0], a[7:2], 2'b11};
    endfunction

    function automatic logic [31:0] dl(input int i);
        if (i < dlog.size()) return dlog[i];
        return 'x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory: accepts when ready, answers in order no earlier than the next cycle.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            memq.delete();
        end else begin
            if (imem_resp_valid) void'(memq.pop_front());
            if (imem_req_valid && imem_req_ready) memq.push_back('{imem_req_addr, cyc});
        end
        #1;
        if (!rst && resp_en && memq.size() > 0 && memq[0].cyc < cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(memq[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
    end

    // Scoreboard: push at request acceptance, flush on redirect, pop on delivery.
    always @(posedge clk) begin
        if (rst) begin
            sb.delete();
            exp_fetch_pc = 32'h0;
        end else if (redirect_valid) begin
            chk("req_valid_in_redirect", {31'b0, imem_req_valid}, 32'd0);
            sb.delete();
            exp_fetch_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (instr_valid && instr_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_instr_valid", {31'b0, instr_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("instr_pc", instr_pc, e.pc);
                    chk("instr_data", instr_data, e.data);
                    chk("instr_opcode", {25'b0, instr_opcode}, {25'b0, e.data[6:0]});
`ifdef IFU_COMPRESSED_CHECK_EN
                    chk("instr_illegal", {31'b0, instr_illegal}, {31'b0, (e.data[1:0] != 2'b11)});
`endif
                    dlog.push_back(instr_pc);
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                chk("req_addr", imem_req_addr, exp_fetch_pc);
                sb.push_back('{exp_fetch_pc, mem_word(exp_fetch_pc)});
                exp_fetch_pc = exp_fetch_pc + 32'd4;
                n_acc++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  m;
        int  m2;
        int  base;
        bit  found;

        rst            = 1'b1;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(negedge clk);
        chk("reset_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("reset_instr_valid", {31'b0, instr_valid}, 32'd0);
`ifdef IFU_COMPRESSED_CHECK_EN
        chk("reset_illegal", {31'b0, instr_illegal}, 32'd0);
`endif

        // Free-running fetch
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("p1_pc0", dl(0), 32'h0);
        chk("p1_pc1", dl(1), 32'h4);
        chk("p1_pc2", dl(2), 32'h8);

        // Decode stall right after reset
        rst         = 1'b1;
        instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        base = n_acc;
        rst  = 1'b0;
        repeat (10) @(negedge clk);
        chk("p2_accepted", n_acc - base, 32'd2);
        chk("p2_instr_valid", {31'b0, instr_valid}, 32'd1);
        chk("p2_head_pc", instr_pc, 32'h0);
        chk("p2_head_data", instr_data, mem_word(32'h0));
        chk("p2_req_valid", {31'b0, imem_req_valid}, 32'd0);
        m = dlog.size();
        instr_ready = 1'b1;

        // Memory back-pressure with 0x10 pending
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (exp_fetch_pc == 32'h10 && imem_req_valid) found = 1'b1;
        end
        chk("p3_reach_0x10", {31'b0, found}, 32'd1);
        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("p3_hold_valid", {31'b0, imem_req_valid}, 32'd1);
            chk("p3_hold_addr", imem_req_addr, 32'h10);
        end
        chk("p2_rel_pc0", dl(m), 32'h0);
        chk("p2_rel_pc1", dl(m + 1), 32'h4);
        chk("p2_rel_pc2", dl(m + 2), 32'h8);
        chk("p2_rel_pc3", dl(m + 3), 32'hC);
        imem_req_ready = 1'b1;

        // Two reads in flight at 0x20/0x24, then redirect to 0x103
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        imem_req_ready = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (3) @(negedge clk);
        resp_en        = 1'b0;
        imem_req_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("p4_inflight", memq.size(), 32'd2);
        chk("p4_req_blocked", {31'b0, imem_req_valid}, 32'd0);
        chk("p4_buf_empty", {31'b0, instr_valid}, 32'd0);
        m              = dlog.size();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        resp_en        = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("p4_next_addr", imem_req_addr, 32'h100);
        repeat (8) @(negedge clk);
        chk("p4_first_pc", dl(m), 32'h100);
        chk("p4_second_pc", dl(m + 1), 32'h104);

        // Redirect coinciding with a response and a decode handshake
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (imem_resp_valid && instr_valid) found = 1'b1;
        end
        chk("p5_collision_found", {31'b0, found}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("p5_flushed", {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        m2             = dlog.size();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("p5_first_pc", dl(m2), 32'h300);
        chk("p5_second_pc", dl(m2 + 1), 32'h304);

        // PC wrap
        m              = dlog.size();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("p6_wrap_pc0", dl(m), 32'hFFFF_FFFC);
        chk("p6_wrap_pc1", dl(m + 1), 32'h0);

        // Drain: nothing lost, nothing extra
        imem_req_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && memq.size() == 0) break;
        end
        chk("drain_sb_empty", sb.size(), 32'd0);
        chk("drain_instr_valid", {31'b0, instr_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
